// File: rtl/fetch_unit.sv
// Instruction fetch unit: a fetch PC feeding a 2-entry {pc, instr} queue
// toward decode, with redirect handling, EBREAK halt and sticky fault
// reporting for misaligned redirects and out-of-range fetches.
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic [1:0]  err_code
);

    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam int          DEPTH      = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] fetch_pc_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  err_reg;
    logic [63:0] q_pc_reg    [DEPTH];
    logic [31:0] q_instr_reg [DEPTH];

    logic redir;
    logic redir_ok;
    logic redir_bad;
    logic in_range;
    logic pop;
    logic push;
    logic fetch_fault;

    // Redirects are dead once faulted; everything else derives from them.
    always_comb begin
        redir       = redirect_valid && (state_reg != ST_ERROR);
        redir_ok    = redir && (redirect_pc[1:0] == 2'b00);
        redir_bad   = redir && (redirect_pc[1:0] != 2'b00);
        in_range    = fetch_pc_reg < IMEM_LIMIT;
        pop         = (count_reg != 2'd0) && out_ready && !redir;
        push        = (state_reg == ST_RUN) && !redir && in_range &&
                      ((count_reg != 2'd2) || pop);
        fetch_fault = (state_reg == ST_RUN) && !redir && !in_range;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: redirect outranks fetch faults and the EBREAK halt.
    always_comb begin
        state_next = state_reg;
        if (redir_bad) begin
            state_next = ST_ERROR;
        end else if (redir_ok) begin
            state_next = ST_RUN;
        end else if (fetch_fault) begin
            state_next = ST_ERROR;
        end else if (push && (imem_instr == EBREAK)) begin
            state_next = ST_HALT;
        end
    end

    // Fetch PC: loaded by an aligned redirect, otherwise advances per push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
        end else if (redir_ok) begin
            fetch_pc_reg <= redirect_pc;
        end else if (push) begin
            fetch_pc_reg <= fetch_pc_reg + 64'd4;
        end
    end

    // Queue pointers and occupancy; any accepted redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (redir) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    // Queue storage, one slot per entry; cleared so outputs read 0 in reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the fetched word when this slot is the tail.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_pc_reg[gi]    <= 64'd0;
                    q_instr_reg[gi] <= 32'd0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    q_pc_reg[gi]    <= fetch_pc_reg;
                    q_instr_reg[gi] <= imem_instr;
                end
            end
        end
    endgenerate

    // Sticky fault code: only the first fault is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 2'b00;
        end else if (err_reg == 2'b00) begin
            if (redir_bad) begin
                err_reg <= 2'b01;
            end else if (fetch_fault) begin
                err_reg <= 2'b10;
            end
        end
    end

    assign imem_pc   = fetch_pc_reg;
    assign out_valid = (count_reg != 2'd0);
    assign out_pc    = q_pc_reg[rd_ptr_reg];
    assign out_instr = q_instr_reg[rd_ptr_reg];
    assign halted    = (state_reg == ST_HALT) && (count_reg == 2'd0);
    assign err_code  = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for streaming, backpressure
// and redirect, plus hand sequences for faults, halt and async reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [1024];

    fetch_unit #(.RESET_PC(64'h0), .IMEM_BYTES(4096)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 64'd4096) ? mem[imem_pc[11:2]] : 32'h0;

    // Unique addi x0,x0,idx per word so lost or duplicated entries show up.
    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return 32'h0000_0013 | {pc[11:2], 20'h0};
    endfunction

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        logic [63:0] eimem;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic rdy,
                                input logic ev, input logic [63:0] epc, input logic [63:0] eimem);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eimem = eimem;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        tick();
        tick();
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_imem",   imem_pc,        64'h0);
        check("rst_outpc",  out_pc,         64'h0);
        check("rst_instr",  64'(out_instr), 64'h0);
        check("rst_err",    64'(err_code),  64'd0);
        check("rst_halted", 64'(halted),    64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(64'(i * 4));

        // Backpressure from reset, streaming release, redirect while full.
        vt[0]  = mk(0, 64'h0,   0, 0, 64'h0,  64'h0);
        vt[1]  = mk(0, 64'h0,   0, 1, 64'h0,  64'h4);
        vt[2]  = mk(0, 64'h0,   0, 1, 64'h0,  64'h8);
        vt[3]  = mk(0, 64'h0,   0, 1, 64'h0,  64'h8);
        vt[4]  = mk(0, 64'h0,   0, 1, 64'h0,  64'h8);
        vt[5]  = mk(0, 64'h0,   1, 1, 64'h0,  64'h8);
        vt[6]  = mk(0, 64'h0,   1, 1, 64'h4,  64'hC);
        vt[7]  = mk(0, 64'h0,   1, 1, 64'h8,  64'h10);
        vt[8]  = mk(0, 64'h0,   1, 1, 64'hC,  64'h14);
        vt[9]  = mk(0, 64'h0,   1, 1, 64'h10, 64'h18);
        vt[10] = mk(0, 64'h0,   0, 1, 64'h14, 64'h1C);
        vt[11] = mk(1, 64'h100, 0, 1, 64'h14, 64'h1C);
        vt[12] = mk(0, 64'h0,   0, 0, 64'h0,  64'h100);
        vt[13] = mk(0, 64'h0,   0, 1, 64'h100, 64'h104);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            out_ready      = vt[i].rdy;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            check($sformatf("v%0d_imem", i), imem_pc, vt[i].eimem);
            if (vt[i].ev) begin
                check($sformatf("v%0d_pc", i), out_pc, vt[i].epc);
                check($sformatf("v%0d_instr", i), 64'(out_instr), 64'(word_at(vt[i].epc)));
            end
            check($sformatf("v%0d_err", i), 64'(err_code), 64'd0);
            $display("vec %0d: valid=%0b pc=%h imem_pc=%h", i, out_valid, out_pc, imem_pc);
            tick();
        end
        redirect_valid = 1'b0;

        // Misaligned redirect faults; a later aligned redirect is ignored.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        tick();
        check("mis_err",   64'(err_code),  64'd1);
        check("mis_valid", 64'(out_valid), 64'd0);
        check("mis_imem",  imem_pc,        64'h0);
        redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        check("mis_ign_err",  64'(err_code), 64'd1);
        check("mis_ign_imem", imem_pc,       64'h0);
        tick();
        check("mis_nofetch", 64'(out_valid), 64'd0);
        $display("misaligned: err=%0d imem_pc=%h", err_code, imem_pc);

        // Fetch running off the end of memory; queued entries still drain.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFF8;
        tick();
        redirect_valid = 1'b0;
        check("oor_imem0", imem_pc, 64'hFF8);
        tick();
        tick();
        check("oor_imem1", imem_pc,       64'h1000);
        check("oor_err0",  64'(err_code), 64'd0);
        tick();
        check("oor_err",   64'(err_code),  64'd2);
        check("oor_valid", 64'(out_valid), 64'd1);
        check("oor_head",  out_pc,         64'hFF8);
        out_ready = 1'b1;
        tick();
        check("oor_pop1", out_pc, 64'hFFC);
        tick();
        check("oor_empty", 64'(out_valid), 64'd0);
        check("oor_imem2", imem_pc,        64'h1000);
        $display("out_of_range: err=%0d valid=%0b", err_code, out_valid);

        // EBREAK at 0x8 halts after draining; redirect resumes fetch.
        mem[2] = 32'h0010_0073;
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("hlt_head8",  out_pc,         64'h8);
        check("hlt_ebreak", 64'(out_instr), 64'h0010_0073);
        check("hlt_notyet", 64'(halted),    64'd0);
        tick();
        check("hlt_halted", 64'(halted),    64'd1);
        check("hlt_imem",   imem_pc,        64'hC);
        tick();
        check("hlt_hold",   64'(out_valid), 64'd0);
        check("hlt_imem2",  imem_pc,        64'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        check("hlt_resume", 64'(halted),    64'd0);
        check("hlt_rimem",  imem_pc,        64'h0);
        tick();
        check("hlt_rvalid", 64'(out_valid), 64'd1);
        check("hlt_rpc",    out_pc,         64'h0);
        $display("halt: halted=%0b out_pc=%h", halted, out_pc);
        mem[2] = word_at(64'h8);

        // Asynchronous reset between edges with a full queue.
        do_reset();
        tick();
        tick();
        check("ar_full", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_imem",  imem_pc,        64'h0);
        check("ar_outpc", out_pc,         64'h0);
        $display("async_reset: valid=%0b imem_pc=%h", out_valid, imem_pc);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
